orbit_pos_latch: RTL and testbench



---
 rtl/orbit_pos_latch.sv | 136 +++++++++++++
 tb/tb_orbit_pos_latch.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/orbit_pos_latch.sv
// Per-frame snapshot of the six orbit coordinates, taken at the start of vblank.
// Build option ORBIT_POS_LATCH_PAUSE_EN adds a 'pause' input that freezes the coordinate outputs.
module orbit_pos_latch #(
    parameter int H_ACTIVE  = 1920,
    parameter int V_ACTIVE  = 1080,
    parameter int MAX_RETRY = 3,
    parameter int FRAME_W   = 16
) (
    input  logic               clk1485,
    input  logic               rst_n,
`ifdef ORBIT_POS_LATCH_PAUSE_EN
    input  logic               pause,
`endif
    input  logic [13:0]        x,
    input  logic [13:0]        y,
    input  logic [10:0]        x_mer_in,
    input  logic [10:0]        y_mer_in,
    input  logic [10:0]        x_ven_in,
    input  logic [10:0]        y_ven_in,
    input  logic [10:0]        x_earth_in,
    input  logic [10:0]        y_earth_in,
    output logic               hold_ticks,
    output logic [10:0]        x_mer,
    output logic [10:0]        y_mer,
    output logic [10:0]        x_ven,
    output logic [10:0]        y_ven,
    output logic [10:0]        x_earth,
    output logic [10:0]        y_earth,
    output logic               pos_valid,
    output logic               commit_pulse,
    output logic               err_unstable,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
    localparam logic [13:0]   Y_TRIG     = 14'(V_ACTIVE);
    // A geometry that does not fit the 14-bit counters can never trigger.
    localparam bit GEOM_OK = (H_ACTIVE > 0) && (H_ACTIVE < 16384) &&
                             (V_ACTIVE >= 0) && (V_ACTIVE < 16384);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SAMPLE_A = 2'd1,
        SAMPLE_B = 2'd2
    } state_e;

    state_e             state_q;
    logic [65:0]        snap_q;
    logic [65:0]        coord_q;
    logic [RW-1:0]      retry_q;
    logic [FRAME_W-1:0] frame_q;
    logic [FRAME_W-1:0] frame_d;
    logic               hold_q;
    logic               valid_q;
    logic               commit_q;
    logic               err_q;

    logic [65:0]        cur;
    logic               trig;
    logic               same;
    logic               upd;

    assign cur     = {x_mer_in, y_mer_in, x_ven_in, y_ven_in, x_earth_in, y_earth_in};
    assign trig    = GEOM_OK && (x == '0) && (y == Y_TRIG);
    assign same    = (cur == snap_q);
    assign frame_d = frame_q + FRAME_W'(1);

`ifdef ORBIT_POS_LATCH_PAUSE_EN
    assign upd = ~pause;
`else
    assign upd = 1'b1;
`endif

    always_ff @(posedge clk1485 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            snap_q   <= '0;
            coord_q  <= '0;
            retry_q  <= '0;
            frame_q  <= '0;
            hold_q   <= 1'b0;
            valid_q  <= 1'b0;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            commit_q <= 1'b0;
            err_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (trig) begin
                        state_q <= SAMPLE_A;
                        hold_q  <= 1'b1;
                    end
                end
                SAMPLE_A: begin
                    snap_q  <= cur;
                    retry_q <= '0;
                    state_q <= SAMPLE_B;
                end
                SAMPLE_B: begin
                    // Two agreeing samples commit; an exhausted retry budget forces a commit.
                    if (same || (retry_q == RETRY_LAST)) begin
                        if (upd) coord_q <= cur;
                        commit_q <= 1'b1;
                        err_q    <= ~same;
                        frame_q  <= frame_d;
                        valid_q  <= 1'b1;
                        hold_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        snap_q  <= cur;
                        retry_q <= retry_q + RW'(1);
                    end
                end
                default: begin
                    hold_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign hold_ticks   = hold_q;
    assign x_mer        = coord_q[65:55];
    assign y_mer        = coord_q[54:44];
    assign x_ven        = coord_q[43:33];
    assign y_ven        = coord_q[32:22];
    assign x_earth      = coord_q[21:11];
    assign y_earth      = coord_q[10:0];
    assign pos_valid    = valid_q;
    assign commit_pulse = commit_q;
    assign err_unstable = err_q;
    assign frame_cnt    = frame_q;

endmodule

// File: tb/tb_orbit_pos_latch.sv
// Scoreboard bench for orbit_pos_latch: reference model predicts per-cycle status and commit events.
module tb_orbit_pos_latch;
    localparam int MAX_RETRY = 3;
    localparam int FRAME_W   = 2;
    localparam int V_ACTIVE  = 1080;
`ifdef ORBIT_POS_LATCH_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [13:0] x = '0, y = '0;
    logic [10:0] x_mer_in = '0, y_mer_in = '0, x_ven_in = '0, y_ven_in = '0, x_earth_in = '0, y_earth_in = '0;
    logic        pause_v = 1'b0;
    logic        hold_ticks, pos_valid, commit_pulse, err_unstable;
    logic [10:0] x_mer, y_mer, x_ven, y_ven, x_earth, y_earth;
    logic [FRAME_W-1:0] frame_cnt;
    logic [65:0] dut_c;
    assign dut_c = {x_mer, y_mer, x_ven, y_ven, x_earth, y_earth};

    orbit_pos_latch #(.H_ACTIVE(1920), .V_ACTIVE(V_ACTIVE), .MAX_RETRY(MAX_RETRY), .FRAME_W(FRAME_W)) dut (
        .clk1485(clk), .rst_n(rst_n),
`ifdef ORBIT_POS_LATCH_PAUSE_EN
        .pause(pause_v),
`endif
        .x(x), .y(y),
        .x_mer_in(x_mer_in), .y_mer_in(y_mer_in), .x_ven_in(x_ven_in), .y_ven_in(y_ven_in),
        .x_earth_in(x_earth_in), .y_earth_in(y_earth_in),
        .hold_ticks(hold_ticks),
        .x_mer(x_mer), .y_mer(y_mer), .x_ven(x_ven), .y_ven(y_ven), .x_earth(x_earth), .y_earth(y_earth),
        .pos_valid(pos_valid), .commit_pulse(commit_pulse), .err_unstable(err_unstable), .frame_cnt(frame_cnt)
    );

    typedef struct { bit hold; bit pv; bit pulse; bit err; logic [65:0] coords; int frame; } cyc_t;
    typedef struct { logic [65:0] coords; bit err; int frame; } cmt_t;
    cyc_t cyc_q[$];
    cmt_t cmt_q[$];
    int errors = 0, checks = 0;

    function automatic void chk(string nm, logic [65:0] act, logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference model: after a trigger from idle, the next edge takes a snapshot;
    // every later edge commits if its inputs equal the previous edge's inputs,
    // or unconditionally (flagged) on the (MAX_RETRY+1)-th comparison.
    bit          busy = 1'b0;
    int          n = 0, t0 = 0;
    logic [65:0] prev = '0, m_out = '0;
    int          m_frame = 0;
    bit          m_pv = 1'b0;

    task automatic step(input logic [13:0] xx, input logic [13:0] yy, input logic [65:0] c,
                        input bit pz, input bit rst);
        cyc_t it;
        bit pulse, err, match;
        @(negedge clk); #1;
        x = xx; y = yy; pause_v = pz;
        {x_mer_in, y_mer_in, x_ven_in, y_ven_in, x_earth_in, y_earth_in} = c;
        pulse = 1'b0; err = 1'b0;
        if (rst) begin
            rst_n = 1'b0; #1;
            chk("rst_hold_now", 66'(hold_ticks), 66'(0));
            chk("rst_coords_now", dut_c, 66'(0));
            chk("rst_valid_now", 66'(pos_valid), 66'(0));
            chk("rst_frame_now", 66'(frame_cnt), 66'(0));
            busy = 1'b0; m_out = '0; m_frame = 0; m_pv = 1'b0;
        end else begin
            rst_n = 1'b1;
            n++;
            if (!busy) begin
                if (xx == 14'd0 && yy == 14'(V_ACTIVE)) begin busy = 1'b1; t0 = n; end
            end else if (n - t0 >= 2) begin
                match = (c == prev);
                if (match || (n - t0 - 1) == MAX_RETRY + 1) begin
                    busy = 1'b0; pulse = 1'b1; err = !match; m_pv = 1'b1;
                    m_frame = (m_frame + 1) % (1 << FRAME_W);
                    if (!(PAUSE_EN && pz)) m_out = c;
                    cmt_q.push_back('{m_out, err, m_frame});
                end
            end
            prev = c;
        end
        it = '{busy, m_pv, pulse, err, m_out, m_frame};
        cyc_q.push_back(it);
    endtask

    function automatic logic [65:0] rnd66();
        logic [65:0] r;
        for (int i = 0; i < 6; i++) r[i*11 +: 11] = 11'($urandom_range(0, 2047));
        return r;
    endfunction

    task automatic idle(input int k, input logic [65:0] c);
        for (int i = 0; i < k; i++)
            step(14'($urandom_range(1, 2199)), 14'($urandom_range(0, 1124)), c, 1'b0, 1'b0);
    endtask

    task automatic trig(input logic [65:0] c);
        step(14'd0, 14'(V_ACTIVE), c, 1'b0, 1'b0);
    endtask

    // Monitor: per-cycle status every cycle, commit events whenever commit_pulse is seen.
    initial begin
        cyc_t e;
        cmt_t m;
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("hold_ticks", 66'(hold_ticks), 66'(e.hold));
                chk("pos_valid", 66'(pos_valid), 66'(e.pv));
                chk("commit_pulse", 66'(commit_pulse), 66'(e.pulse));
                chk("err_unstable", 66'(err_unstable), 66'(e.err));
                chk("coords", dut_c, e.coords);
                chk("frame_cnt", 66'(frame_cnt), 66'(e.frame));
            end
            if (commit_pulse === 1'b1) begin
                if (cmt_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_commit: got commit_pulse=1 expected no commit (t=%0t)", $time);
                end else begin
                    m = cmt_q.pop_front();
                    chk("commit_coords", dut_c, m.coords);
                    chk("commit_err", 66'(err_unstable), 66'(m.err));
                    chk("commit_frame", 66'(frame_cnt), 66'(m.frame));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [65:0] c0, c1, c2, c3, c;
        int mode;
        bit pz;
        c0 = {11'd1000, 11'd540, 11'd300, 11'd200, 11'd1500, 11'd900};
        c1 = c0; c1[43:33] = 11'd777;

        // Reset state, then stable commit at E2
        for (int i = 0; i < 3; i++) step(14'd5, 14'd5, c0, 1'b0, 1'b1);
        idle(3, c0);
        trig(c0);
        idle(5, c0);

        // Single glitch between E1 and E2 -> commit at E3, no error
        trig(c0);
        idle(1, c0);
        idle(5, c1);

        // Continuous toggling -> forced commit at E5
        trig(rnd66());
        for (int i = 0; i < 8; i++) idle(1, rnd66());

        // Mid-frame change at y=500 holds outputs; re-trigger during SAMPLE_B ignored
        c2 = rnd66(); c3 = rnd66();
        for (int i = 0; i < 10; i++) step(14'($urandom_range(0, 1919)), 14'd500, rnd66(), 1'b0, 1'b0);
        idle(2, c2);
        trig(c2);
        idle(1, c2);
        trig(c3);
        trig(c3);
        idle(4, c3);

        // Reset while in SAMPLE_B, then a normal frame
        trig(c0);
        idle(1, c0);
        idle(1, c1);
        step(14'd7, 14'd7, c1, 1'b0, 1'b1);
        step(14'd7, 14'd7, c1, 1'b0, 1'b1);
        idle(2, c2);
        trig(c2);
        idle(4, c2);

        // Five back-to-back frames wrap the 2-bit counter
        for (int f = 0; f < 5; f++) begin
            c = rnd66();
            trig(c);
            idle(4, c);
        end

        // Randomized frames with varying input stability (and pause when built in)
        for (int f = 0; f < 40; f++) begin
            mode = $urandom_range(0, 2);
            c = rnd66();
            pz = PAUSE_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            step(14'd0, 14'(V_ACTIVE), c, pz, 1'b0);
            for (int i = 0; i < 8; i++) begin
                if (mode == 2 || (mode == 1 && $urandom_range(0, 2) == 0)) c = rnd66();
                step(14'($urandom_range(1, 2199)), 14'($urandom_range(0, 1124)), c, pz, 1'b0);
            end
            for (int i = 0; i < int'($urandom_range(0, 5)); i++) idle(1, rnd66());
        end
        idle(3, c);

        @(negedge clk); @(negedge clk); #3;
        chk("cyc_queue_drained", 66'(cyc_q.size()), 66'(0));
        chk("commit_queue_drained", 66'(cmt_q.size()), 66'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
